// File: rtl/cmp_issuer_if.sv
// Signal bundle for cmp_issuer: command intake, compare-unit drive/result and response output.
// The slave side belongs to cmp_issuer; the master side is its environment.
interface cmp_issuer_if #(
    parameter int W  = 32,
    parameter int TW = 4
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_fcn;
    logic [W-1:0]  cmd_a;
    logic [W-1:0]  cmd_b;
    logic [TW-1:0] cmd_tag;

    logic [3:0]    cmp_fcn;
    logic [W-1:0]  cmp_a;
    logic [W-1:0]  cmp_b;
    logic          cmp_o;

    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_o;
    logic          rsp_err;
    logic [TW-1:0] rsp_tag;

    modport slave (
        input  cmd_valid, cmd_fcn, cmd_a, cmd_b, cmd_tag, cmp_o, rsp_ready,
        output cmd_ready, cmp_fcn, cmp_a, cmp_b, rsp_valid, rsp_o, rsp_err, rsp_tag
    );

    modport master (
        output cmd_valid, cmd_fcn, cmd_a, cmd_b, cmd_tag, cmp_o, rsp_ready,
        input  cmd_ready, cmp_fcn, cmp_a, cmp_b, rsp_valid, rsp_o, rsp_err, rsp_tag
    );
endinterface

// File: rtl/cmp_issuer.sv
// Issues compare commands to a fixed-latency external compare unit and returns the results
// in issue order through a credit-limited result FIFO.
module cmp_issuer #(
    parameter int W   = 32,
    parameter int LAT = 2,
    parameter int D   = 4,
    parameter int TW  = 4
) (
    input  logic        clk,
    input  logic        rst,
    cmp_issuer_if.slave bus_io
);
    localparam int CW = $clog2(D + 1);
    localparam int PW = $clog2(D);
    localparam int EW = TW + 2;
    localparam logic [CW:0] DEPTH = (CW + 1)'(D);

    logic            alive_q;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   stored_q, stored_d;
    logic [CW:0]     occupancy;
    logic [PW-1:0]   wrPtr_q, rdPtr_q;
    logic [EW-1:0]   fifoMem_q [D];
    logic [LAT-1:0]  pipeValid_q;
    logic [LAT-1:0]  pipeErr_q;
    logic [TW-1:0]   pipeTag_q [LAT];
    logic [3:0]      cmpFcn_q;
    logic [W-1:0]    cmpA_q, cmpB_q;
    logic            accept, capture, pop;
    logic [EW-1:0]   captureEntry, headEntry;

    // Every accepted command holds a credit from issue until its response is popped.
    assign occupancy        = {1'b0, inflight_q} + {1'b0, stored_q};
    assign bus_io.cmd_ready = alive_q && (occupancy < DEPTH);

    assign accept  = bus_io.cmd_valid && bus_io.cmd_ready;
    assign capture = pipeValid_q[LAT-1];
    assign pop     = bus_io.rsp_valid && bus_io.rsp_ready;

    assign captureEntry = {bus_io.cmp_o & ~pipeErr_q[LAT-1], pipeErr_q[LAT-1], pipeTag_q[LAT-1]};
    assign headEntry    = fifoMem_q[rdPtr_q];

    assign bus_io.rsp_valid = (stored_q != '0);
    assign {bus_io.rsp_o, bus_io.rsp_err, bus_io.rsp_tag} = bus_io.rsp_valid ? headEntry : '0;

    assign bus_io.cmp_fcn = cmpFcn_q;
    assign bus_io.cmp_a   = cmpA_q;
    assign bus_io.cmp_b   = cmpB_q;

    always_comb begin
        inflight_d = inflight_q;
        stored_d   = stored_q;
        if (accept && !capture) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!accept && capture) begin
            inflight_d = inflight_q - 1'b1;
        end
        if (capture && !pop) begin
            stored_d = stored_q + 1'b1;
        end else if (!capture && pop) begin
            stored_d = stored_q - 1'b1;
        end
    end

    // Clearing the pipe valid bits on reset is what makes late cmp_o samples harmless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alive_q     <= 1'b0;
            inflight_q  <= '0;
            stored_q    <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            pipeValid_q <= '0;
            pipeErr_q   <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipeTag_q[i] <= '0;
            end
            cmpFcn_q    <= '0;
            cmpA_q      <= '0;
            cmpB_q      <= '0;
        end else begin
            alive_q    <= 1'b1;
            inflight_q <= inflight_d;
            stored_q   <= stored_d;
            if (capture) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            pipeValid_q[0] <= accept;
            pipeErr_q[0]   <= (bus_io.cmd_fcn >= 4'd10);
            pipeTag_q[0]   <= bus_io.cmd_tag;
            for (int i = 1; i < LAT; i++) begin
                pipeValid_q[i] <= pipeValid_q[i-1];
                pipeErr_q[i]   <= pipeErr_q[i-1];
                pipeTag_q[i]   <= pipeTag_q[i-1];
            end
            if (accept) begin
                cmpFcn_q <= bus_io.cmd_fcn;
                cmpA_q   <= bus_io.cmd_a;
                cmpB_q   <= bus_io.cmd_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            fifoMem_q[wrPtr_q] <= captureEntry;
        end
    end
endmodule

// File: tb/tb_cmp_issuer.sv
// Self-checking bench for cmp_issuer: models the external compare unit and predicts every
// response from an ordered queue of outstanding commands.
module tb_cmp_issuer;
    localparam int W   = 32;
    localparam int LAT = 2;
    localparam int D   = 4;
    localparam int TW  = 4;

    typedef struct {
        logic          o;
        logic          err;
        logic [TW-1:0] tag;
        int            readyCycle;
    } entry_t;

    logic clk = 1'b0;
    logic rst;

    cmp_issuer_if #(.W(W), .TW(TW)) bus ();

    cmp_issuer #(.W(W), .LAT(LAT), .D(D), .TW(TW)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    entry_t       expQ[$];
    logic         schedValid [16];
    logic         schedVal   [16];
    int           cyc;
    int           testsRun;
    int           testsFailed;
    int           dutAccepts;
    logic         alive;
    logic [3:0]   lastFcn;
    logic [W-1:0] lastA, lastB;
    logic         acc;

    // The external compare unit's behaviour; illegal functions are forced to 1 so the masking shows.
    function automatic logic refCompare(input logic [3:0] fcn, input logic [W-1:0] a, input logic [W-1:0] b);
        case (fcn)
            4'd0:    return a == b;
            4'd1:    return a != b;
            4'd2:    return a < b;
            4'd3:    return a >= b;
            4'd4:    return $signed(a) < $signed(b);
            4'd5:    return $signed(a) >= $signed(b);
            4'd6:    return a > b;
            4'd7:    return a <= b;
            4'd8:    return 1'b1;
            4'd9:    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic checkResetState();
        checkOutput("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("rst_rsp_fields", 64'({bus.rsp_o, bus.rsp_err, bus.rsp_tag}), 64'd0);
        checkOutput("rst_cmp_fcn", 64'(bus.cmp_fcn), 64'd0);
        checkOutput("rst_cmp_ab", {bus.cmp_a, bus.cmp_b}, 64'd0);
    endtask

    // One clock cycle: drive inputs, check the state visible in this cycle, advance the model.
    task automatic applyStimulus(input logic v, input logic [3:0] fcn, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [TW-1:0] tag, input logic rr,
                                 output logic accepted);
        logic   modelReady;
        logic   modelValid;
        logic   res;
        entry_t e;
        bus.cmd_valid = v;
        bus.cmd_fcn   = fcn;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_tag   = tag;
        bus.rsp_ready = rr;
        if (schedValid[cyc % 16]) begin
            bus.cmp_o = schedVal[cyc % 16];
            schedValid[cyc % 16] = 1'b0;
        end else begin
            bus.cmp_o = 1'($urandom_range(0, 1));
        end
        #1;
        modelReady = alive && (expQ.size() < D);
        modelValid = (expQ.size() > 0) && (expQ[0].readyCycle <= cyc);
        checkOutput("cmd_ready", 64'(bus.cmd_ready), 64'(modelReady));
        checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'(modelValid));
        if (modelValid) begin
            checkOutput("rsp_fields", 64'({bus.rsp_o, bus.rsp_err, bus.rsp_tag}),
                        64'({expQ[0].o, expQ[0].err, expQ[0].tag}));
        end
        checkOutput("cmp_fcn", 64'(bus.cmp_fcn), 64'(lastFcn));
        checkOutput("cmp_ab", {bus.cmp_a, bus.cmp_b}, {lastA, lastB});
        if (v && bus.cmd_ready) dutAccepts++;
        accepted = v && modelReady;
        if (modelValid && rr) void'(expQ.pop_front());
        if (accepted) begin
            res          = refCompare(fcn, a, b);
            e.err        = (fcn >= 4'd10);
            e.o          = res && !e.err;
            e.tag        = tag;
            e.readyCycle = cyc + LAT + 1;
            expQ.push_back(e);
            schedValid[(cyc + LAT) % 16] = 1'b1;
            schedVal[(cyc + LAT) % 16]   = res;
            lastFcn = fcn;
            lastA   = a;
            lastB   = b;
        end
        alive = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idleCycles(input int n, input logic rr);
        logic dummy;
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 4'($urandom_range(0, 15)), $urandom, $urandom, TW'($urandom), rr, dummy);
        end
    endtask

    task automatic randomCommand(input logic v, input logic [TW-1:0] tag, input logic rr, output logic accepted);
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = $urandom;
        b = ($urandom_range(0, 2) == 0) ? a : W'($urandom);
        applyStimulus(v, 4'($urandom_range(0, 15)), a, b, tag, rr, accepted);
    endtask

    task automatic doReset();
        rst = 1'b1;
        bus.cmp_o = 1'b1;
        #2;
        checkResetState();
        @(posedge clk);
        #1;
        cyc++;
        checkResetState();
        rst = 1'b0;
        expQ.delete();
        alive   = 1'b0;
        lastFcn = '0;
        lastA   = '0;
        lastB   = '0;
    endtask

    initial begin
        int start;
        int idx;
        testsRun = 0; testsFailed = 0; cyc = 0; dutAccepts = 0;
        alive = 1'b0; lastFcn = '0; lastA = '0; lastB = '0;
        for (int i = 0; i < 16; i++) begin
            schedValid[i] = 1'b0;
            schedVal[i]   = 1'b0;
        end
        bus.cmd_valid = 1'b0; bus.cmd_fcn = '0; bus.cmd_a = '0; bus.cmd_b = '0;
        bus.cmd_tag = '0; bus.rsp_ready = 1'b0; bus.cmp_o = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkResetState();
        rst = 1'b0;
        idleCycles(1, 1'b1);

        // Single legal command, then an illegal one between two legal neighbours.
        applyStimulus(1'b1, 4'd0, 32'd5, 32'd5, 4'd3, 1'b1, acc);
        idleCycles(5, 1'b1);
        applyStimulus(1'b1, 4'd1, 32'd10, 32'd20, 4'd6, 1'b1, acc);
        applyStimulus(1'b1, 4'd12, 32'd7, 32'd7, 4'd7, 1'b1, acc);
        applyStimulus(1'b1, 4'd0, 32'd9, 32'd9, 4'd8, 1'b1, acc);
        idleCycles(5, 1'b1);

        // Backpressure: six commands offered with the consumer stalled.
        start = dutAccepts;
        idx   = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 4'(idx), W'(idx * 3), W'(idx * 3), TW'(idx), 1'b0, acc);
            if (acc) idx++;
        end
        checkOutput("bp_accepted", 64'(dutAccepts - start), 64'd4);
        checkOutput("bp_ready_low", 64'(bus.cmd_ready), 64'd0);
        for (int i = 0; i < 30 && idx < 6; i++) begin
            applyStimulus(1'b1, 4'(idx), W'(idx * 3), W'(idx * 3), TW'(idx), 1'b1, acc);
            if (acc) idx++;
        end
        checkOutput("bp_total_accepted", 64'(dutAccepts - start), 64'd6);
        idleCycles(6, 1'b1);

        // Streaming: one accept per cycle with the consumer always ready.
        start = dutAccepts;
        idx   = 0;
        for (int i = 0; i < 100; i++) begin
            randomCommand(1'b1, TW'(idx), 1'b1, acc);
            if (acc) idx++;
        end
        checkOutput("stream_accepts", 64'(dutAccepts - start), 64'd100);
        idleCycles(6, 1'b1);

        // Random traffic with random consumer stalls.
        idx = 0;
        for (int i = 0; i < 300; i++) begin
            randomCommand(1'($urandom_range(0, 3) != 0), TW'(idx), 1'($urandom_range(0, 2) != 0), acc);
            if (acc) idx++;
        end
        idleCycles(8, 1'b1);

        // Reset with one buffered response and two commands in flight.
        applyStimulus(1'b1, 4'd0, 32'd1, 32'd1, 4'd9, 1'b0, acc);
        idleCycles(3, 1'b0);
        applyStimulus(1'b1, 4'd0, 32'd2, 32'd2, 4'd10, 1'b0, acc);
        applyStimulus(1'b1, 4'd0, 32'd3, 32'd3, 4'd11, 1'b0, acc);
        checkOutput("pre_reset_buffered", 64'(bus.rsp_valid), 64'd1);
        doReset();
        idleCycles(1, 1'b1);
        checkOutput("post_reset_ready", 64'(bus.cmd_ready), 64'd1);
        idleCycles(6, 1'b1);
        applyStimulus(1'b1, 4'd2, 32'd1, 32'd2, 4'd5, 1'b1, acc);
        idleCycles(5, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
